uart_transmitter: RTL

//   Serial-line transmitter; upstream counterpart of the receiver. Accepts a

---
 rtl/uart_transmitter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB first, one stop bit,
// each bit held CLKS_PER_BIT clocks. All outputs are registered.
module uart_transmitter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  data_out,
    output logic                  busy,
    output logic                  character_sent
);

    localparam int unsigned SAMPLE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  sent_q, sent_d;
    logic                  bit_end;

    assign data_out       = data_out_q;
    assign busy           = busy_q;
    assign character_sent = sent_q;
    assign bit_end        = (sample_q == SAMPLE_LAST);

    // State and datapath registers; reset leaves the line idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            sample_q   <= '0;
            data_out_q <= 1'b1;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            sample_q   <= sample_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
        end
    end

    // Next-state and next-output logic; the sample counter paces each bit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        sample_d   = sample_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;

        case (state_q)
            IDLE: begin
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                if (load) begin
                    state_d    = START;
                    shift_d    = data_in;
                    bit_d      = '0;
                    sample_d   = '0;
                    data_out_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    sample_d   = '0;
                    bit_d      = '0;
                    data_out_d = shift_q[0];
                    shift_d    = shift_q >> 1;
                end else begin
                    sample_d = sample_q + SAMPLE_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    sample_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d    = STOP;
                        data_out_d = 1'b1;
                    end else begin
                        bit_d      = bit_q + BIT_W'(1);
                        data_out_d = shift_q[0];
                        shift_d    = shift_q >> 1;
                    end
                end else begin
                    sample_d = sample_q + SAMPLE_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d    = IDLE;
                    sample_d   = '0;
                    data_out_d = 1'b1;
                    busy_d     = 1'b0;
                    sent_d     = 1'b1;
                end else begin
                    sample_d = sample_q + SAMPLE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
